// File: rtl/fp_norm_round_pack_if.sv
// fp_norm_round_pack_if: valid/ready bus between the adder (master) and the normalize/round/pack stage (slave)
interface fp_norm_round_pack_if #(
  parameter int MW = 10,
  parameter int EW = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [MW:0]      in_mant;
  logic [EW:0]      in_exp;
  logic             in_sgn;
  logic             out_valid;
  logic             out_ready;
  logic [MW+EW:0]   out_word;
  logic             ovf;
  logic             unf;
  logic             zero;
  modport master (
    output in_valid, in_mant, in_exp, in_sgn, out_ready,
    input  in_ready, out_valid, out_word, ovf, unf, zero
  );
  modport slave (
    input  in_valid, in_mant, in_exp, in_sgn, out_ready,
    output in_ready, out_valid, out_word, ovf, unf, zero
  );
endinterface

// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: iterative normalize, round-to-nearest-even and pack stage (ports: clk, reset, slave bus with in/out valid-ready, out_word, ovf/unf/zero)
module fp_norm_round_pack #(
  parameter int MW   = 10,
  parameter int EW   = 5,
  parameter int EMAX = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_norm_round_pack_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;
  localparam logic [EW+1:0] E_ONE = (EW+2)'(1);
  localparam logic [EW+1:0] E_MAX = (EW+2)'(EMAX);
  localparam logic [MW:0]   M_ONE = (MW+1)'(1);
  localparam logic [MW:0]   M_OVF = M_ONE << MW;
  state_t            state_q, state_d;
  logic [MW:0]       m_q, m_d;
  logic [EW+1:0]     e_q, e_d;
  logic              s_q, s_d;
  logic              g_q, g_d;
  logic              st_q, st_d;
  logic              rr_q, rr_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [MW+EW:0]    word_q, word_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;
  logic [MW:0]       m_inc;
  logic [MW+EW:0]    zero_word;
  assign m_inc     = m_q + M_ONE;
  assign zero_word = {s_q, {(MW+EW){1'b0}}};
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    s_d     = s_q;
    g_d     = g_q;
    st_d    = st_q;
    rr_d    = rr_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        m_d     = bus.in_mant;
        e_d     = {1'b0, bus.in_exp};
        s_d     = bus.in_sgn;
        g_d     = 1'b0;
        st_d    = 1'b0;
        rr_d    = 1'b0;
        state_d = NORM;
      end
      NORM: if (m_q == '0) begin
        word_d  = zero_word;
        zero_d  = 1'b1;
        state_d = DONE;
      end else if (m_q[MW]) begin
        m_d  = m_q >> 1;
        g_d  = m_q[0];
        st_d = st_q | g_q;
        e_d  = e_q + E_ONE;
      end else if (!m_q[MW-1]) begin
        if (e_q <= E_ONE) begin
          word_d  = zero_word;
          unf_d   = 1'b1;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          m_d = {m_q[MW-1:0], g_q};
          g_d = 1'b0;
          e_d = e_q - E_ONE;
        end
      end else begin
        state_d = ROUND;
      end
      ROUND: if (g_q & (st_q | m_q[0]) & !rr_q) begin
        m_d     = m_inc;
        g_d     = 1'b0;
        rr_d    = m_inc == M_OVF;
        state_d = (m_inc == M_OVF) ? NORM : PACK;
      end else begin
        state_d = PACK;
      end
      PACK: begin
        word_d  = (e_q > E_MAX) ? {s_q, {EW{1'b1}}, {MW{1'b1}}} :
                  (e_q == '0)   ? zero_word : {s_q, e_q[EW-1:0], m_q[MW-1:0]};
        ovf_d   = e_q > E_MAX;
        unf_d   = e_q == '0;
        zero_d  = e_q == '0;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        zero_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      g_q         <= 1'b0;
      st_q        <= 1'b0;
      rr_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      word_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      g_q         <= g_d;
      st_q        <= st_d;
      rr_q        <= rr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      zero_q      <= zero_d;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = word_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_fp_norm_round_pack.sv
// tb_fp_norm_round_pack: directed-vector bench for the normalize/round/pack stage
module tb_fp_norm_round_pack;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  fp_norm_round_pack_if bus ();
  fp_norm_round_pack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic run(input string tag, input logic [10:0] mant, input logic [5:0] ex,
                     input logic sg, input logic [15:0] w, input logic ov, input logic un,
                     input logic zr, input int lat, input int hold);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_mant  = mant;
    bus.in_exp   = ex;
    bus.in_sgn   = sg;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".word"}, bus.out_word, w);
    chk({tag, ".ovf"}, bus.ovf, ov);
    chk({tag, ".unf"}, bus.unf, un);
    chk({tag, ".zero"}, bus.zero, zr);
    bus.in_valid = hold > 0;
    bus.in_mant  = 11'h200;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_word"}, bus.out_word, w);
      chk({tag, ".hold_flags"}, {bus.ovf, bus.unf, bus.zero}, {ov, un, zr});
      chk({tag, ".hold_valid"}, bus.out_valid, 1);
      chk({tag, ".hold_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, ".handoff_valid"}, bus.out_valid, 0);
    chk({tag, ".handoff_in_ready"}, bus.in_ready, 1);
    chk({tag, ".handoff_flags"}, {bus.ovf, bus.unf, bus.zero}, 3'b000);
    @(posedge clk);
    #1;
    chk({tag, ".not_captured"}, bus.in_ready, 1);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sgn    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", bus.in_ready, 1);
    chk("reset.out_valid", bus.out_valid, 0);
    chk("reset.word", bus.out_word, 16'h0000);
    chk("reset.flags", {bus.ovf, bus.unf, bus.zero}, 3'b000);
    reset = 1'b0;
    run("normal",     11'h200, 6'd15, 1'b0, 16'h3E00, 1'b0, 1'b0, 1'b0, 3,  0);
    run("tie_even",   11'h401, 6'd15, 1'b0, 16'h4200, 1'b0, 1'b0, 1'b0, 4,  0);
    run("round_up",   11'h403, 6'd15, 1'b0, 16'h4202, 1'b0, 1'b0, 1'b0, 4,  0);
    run("cancel",     11'h001, 6'd20, 1'b0, 16'h2E00, 1'b0, 1'b0, 1'b0, 12, 0);
    run("flush",      11'h001, 6'd5,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 5,  0);
    run("reround_ov", 11'h7FF, 6'd31, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 7,  0);
    run("exact_zero", 11'h000, 6'd9,  1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1,  0);
    run("neg_normal", 11'h2AB, 6'd1,  1'b1, 16'h86AB, 1'b0, 1'b0, 1'b0, 3,  0);
    run("backpress",  11'h403, 6'd15, 1'b1, 16'hC202, 1'b0, 1'b0, 1'b0, 4,  5);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = 11'h001;
    bus.in_exp   = 6'd20;
    bus.in_sgn   = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_norm.busy", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_reset.out_valid", bus.out_valid, 0);
    chk("mid_reset.in_ready", bus.in_ready, 1);
    chk("mid_reset.word", bus.out_word, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_reset.discarded", bus.out_valid, 0);
    run("after_reset", 11'h200, 6'd15, 1'b0, 16'h3E00, 1'b0, 1'b0, 1'b0, 3, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
